// File: rtl/fft_tf_sequencer.sv
// Frame-aware twiddle address sequencer for one radix-2 DIF stage; tf_valid/pair_idx trail an accept by 1+ROM_LAT cycles.
// Optional frame counter output enabled by defining FFT_TF_FRAME_CNT_EN.
module fft_tf_sequencer #(
   parameter int ADDR_LEN    = 13,
   parameter int STAGE       = 0,
   parameter int TF_ADDR_LEN = 12,
   parameter int ROM_LAT     = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   tf_en,
   output logic [TF_ADDR_LEN-1:0] tf_addr,
   output logic                   tf_valid,
   output logic [ADDR_LEN-2:0]    pair_idx,
   output logic                   busy,
   output logic                   frame_done
`ifdef FFT_TF_FRAME_CNT_EN
   ,
   output logic [15:0]            frame_cnt
`endif
);

   localparam int KW     = ADDR_LEN - 1;
   localparam int H_BITS = (STAGE >= 0 && STAGE <= ADDR_LEN - 1) ? ADDR_LEN - 1 - STAGE : 0;
   // k mod H == k & (H-1) since H is a power of two
   localparam logic [KW-1:0] K_MASK = KW'((64'd1 << H_BITS) - 64'd1);
   localparam logic [KW-1:0] K_LAST = '1;

   generate
      if (STAGE < 0 || STAGE > ADDR_LEN - 1) begin : g_bad_stage
         $error("fft_tf_sequencer: STAGE out of range 0..ADDR_LEN-1");
      end
      if (TF_ADDR_LEN != ADDR_LEN - 1) begin : g_bad_tf_width
         $error("fft_tf_sequencer: TF_ADDR_LEN must equal ADDR_LEN-1");
      end
      if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
         $error("fft_tf_sequencer: ROM_LAT must be 1..4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [KW-1:0]   k;
   logic [KW-1:0]   addr_nxt;
   logic            accept;
   logic [ROM_LAT:0] en_sr;
   logic [KW-1:0]   idx_sr [0:ROM_LAT];
   logic [TF_ADDR_LEN-1:0] tf_addr_q;

   assign accept   = in_valid & in_ready;
   assign addr_nxt = (k & K_MASK) << STAGE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // frame_done fires once the whole read pipeline, tf_en included, has emptied
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && k == K_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (en_sr == '0) begin
               frame_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k <= '0;
      end else if (state == IDLE && start) begin
         k <= '0;
      end else if (accept) begin
         k <= k + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tf_addr_q <= '0;
      end else if (accept) begin
         tf_addr_q <= TF_ADDR_LEN'(addr_nxt);
      end
   end

   // en_sr[0] is tf_en itself; en_sr[ROM_LAT] lines up with BRAM read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_sr <= '0;
      end else begin
         en_sr <= {en_sr[ROM_LAT-1:0], accept};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= ROM_LAT; i++) idx_sr[i] <= '0;
      end else begin
         idx_sr[0] <= k;
         for (int i = 1; i <= ROM_LAT; i++) idx_sr[i] <= idx_sr[i-1];
      end
   end

   assign tf_en    = en_sr[0];
   assign tf_addr  = tf_addr_q;
   assign tf_valid = en_sr[ROM_LAT];
   assign pair_idx = tf_valid ? idx_sr[ROM_LAT] : '0;
   assign busy     = (state != IDLE);

`ifdef FFT_TF_FRAME_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (frame_done) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fft_tf_sequencer.sv
// Scoreboard bench: three stage/latency configurations of fft_tf_sequencer share one stimulus stream.
module tb_fft_tf_sequencer;

   localparam int AL = 4;
   localparam int KW = AL - 1;
   localparam int NP = 8;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic in_valid;

   logic [NI-1:0] in_ready_w, tf_en_w, tf_valid_w, busy_w, fd_w;
   logic [KW-1:0] tf_addr_w  [NI];
   logic [KW-1:0] pair_idx_w [NI];
`ifdef FFT_TF_FRAME_CNT_EN
   logic [15:0]   fcnt_w     [NI];
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt [NI];
   int exp_frames = 0;
   int addr_s1 [8] = '{0, 2, 4, 6, 0, 2, 4, 6};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_addr(input int st, input int k);
      case (st)
         0:       return k;
         1:       return addr_s1[k];
         default: return 0;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : gen_dut
      localparam int ST = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      localparam int RL = (g == 0) ? 1 : (g == 1) ? 3 : 2;

      fft_tf_sequencer #(
         .ADDR_LEN(AL), .STAGE(ST), .TF_ADDR_LEN(AL - 1), .ROM_LAT(RL)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
         .in_ready(in_ready_w[g]), .tf_en(tf_en_w[g]), .tf_addr(tf_addr_w[g]),
         .tf_valid(tf_valid_w[g]), .pair_idx(pair_idx_w[g]), .busy(busy_w[g]),
         .frame_done(fd_w[g])
`ifdef FFT_TF_FRAME_CNT_EN
         , .frame_cnt(fcnt_w[g])
`endif
      );

      int a_q[$], a_cyc_q[$], v_q[$], v_cyc_q[$];
      int k_m = 0;
      int last_v = -100;
      int frame_v = 0;

      // expectation recorder: handshake seen in cycle c is accepted at the edge ending c
      always @(negedge clk) begin
         if (rst) begin
            a_q.delete(); a_cyc_q.delete(); v_q.delete(); v_cyc_q.delete();
            k_m = 0;
         end else if (in_valid && in_ready_w[g]) begin
            a_q.push_back(exp_addr(ST, k_m));
            a_cyc_q.push_back(cyc + 1);
            v_q.push_back(k_m);
            v_cyc_q.push_back(cyc + 1 + RL);
            k_m = (k_m + 1) % NP;
         end
      end

      always @(negedge clk) begin
         if (rst) begin
            frame_v = 0;
         end else begin
            if (tf_en_w[g]) begin
               if (a_q.size() == 0) chk($sformatf("tf_en_unexpected[%0d]", g), 1, 0);
               else begin
                  chk($sformatf("tf_addr[%0d]", g), int'(tf_addr_w[g]), a_q.pop_front());
                  chk($sformatf("tf_en_cycle[%0d]", g), cyc, a_cyc_q.pop_front());
               end
            end
            if (tf_valid_w[g]) begin
               if (v_q.size() == 0) chk($sformatf("tf_valid_unexpected[%0d]", g), 1, 0);
               else begin
                  chk($sformatf("pair_idx[%0d]", g), int'(pair_idx_w[g]), v_q.pop_front());
                  chk($sformatf("tf_valid_cycle[%0d]", g), cyc, v_cyc_q.pop_front());
               end
               last_v = cyc;
               frame_v++;
            end else begin
               chk($sformatf("pair_idx_idle[%0d]", g), int'(pair_idx_w[g]), 0);
            end
            if (fd_w[g]) begin
               chk($sformatf("frame_done_cycle[%0d]", g), cyc, last_v + 1);
               chk($sformatf("frame_pairs[%0d]", g), frame_v, NP);
               frame_v = 0;
               done_cnt[g]++;
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk({tag, "_in_ready"}, int'(in_ready_w[i]), 0);
         chk({tag, "_tf_en"}, int'(tf_en_w[i]), 0);
         chk({tag, "_tf_addr"}, int'(tf_addr_w[i]), 0);
         chk({tag, "_tf_valid"}, int'(tf_valid_w[i]), 0);
         chk({tag, "_pair_idx"}, int'(pair_idx_w[i]), 0);
         chk({tag, "_busy"}, int'(busy_w[i]), 0);
         chk({tag, "_frame_done"}, int'(fd_w[i]), 0);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_w != '0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_reached", int'(busy_w), 0);
      for (int i = 0; i < NI; i++) chk("frames_done", done_cnt[i], exp_frames);
   endtask

   // Feeds one frame; optional gaps and stray start pulses in RUN and DRAIN.
   task automatic run_frame(input bit gapped, input bit poke_start);
      int acc = 0;
      int n = 0;
      pulse_start();
      while (acc < NP && n < 100) begin
         in_valid = !gapped || (n % 2 == 0);
         start    = poke_start && (n == 3);
         @(negedge clk);
         if (in_valid && in_ready_w[0]) acc++;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("accept_count", acc, NP);
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) chk("ready_after_frame", int'(in_ready_w[i]), 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (poke_start) pulse_start();
      exp_frames++;
      wait_idle();
   endtask

   initial begin
      int acc;
      for (int i = 0; i < NI; i++) done_cnt[i] = 0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_frame(1'b0, 1'b0);   // back-to-back pairs
      run_frame(1'b1, 1'b0);   // 1,0,1,0 gaps
      run_frame(1'b0, 1'b1);   // stray starts in RUN and DRAIN
      run_frame(1'b0, 1'b0);   // immediate restart from IDLE

      // abort after pair 3 is accepted
      pulse_start();
      in_valid = 1'b1;
      acc = 0;
      for (int n = 0; n < 20 && acc < 4; n++) begin
         @(negedge clk);
         if (in_ready_w[0]) acc++;
         @(posedge clk); #1;
      end
      chk("abort_accepts", acc, 4);
      chk("abort_tf_en_before", int'(tf_en_w[0]), 1);
      #1 rst = 1'b1; in_valid = 1'b0;
      #1;
      check_all_zero("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("post_abort");
      for (int i = 0; i < NI; i++) chk("abort_no_done", done_cnt[i], exp_frames);

      run_frame(1'b0, 1'b0);   // fresh frame after abort

`ifdef FFT_TF_FRAME_CNT_EN
      for (int i = 0; i < NI; i++) chk("frame_cnt", int'(fcnt_w[i]), 5);
      force gen_dut[0].u_dut.frame_cnt = 16'hFFFF;
      force gen_dut[1].u_dut.frame_cnt = 16'hFFFF;
      force gen_dut[2].u_dut.frame_cnt = 16'hFFFF;
      #1;
      release gen_dut[0].u_dut.frame_cnt;
      release gen_dut[1].u_dut.frame_cnt;
      release gen_dut[2].u_dut.frame_cnt;
      run_frame(1'b0, 1'b0);
      for (int i = 0; i < NI; i++) chk("frame_cnt_wrap", int'(fcnt_w[i]), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
